pc_sequencer: RTL and testbench



---
 rtl/rv_core_pkg.sv | 21 ++
 rtl/pc_sequencer_if.sv | 28 ++
 rtl/pc_sequencer_redirect_detect.sv | 28 ++
 rtl/pc_sequencer.sv | 121 ++++++++++++
 tb/tb_pc_sequencer.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/rv_core_pkg.sv
// Shared core types and constants for the fetch-PC sequencer: FSM state
// encoding, PC increment and the default post-reset fetch address.
package rv_core_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } seq_state_t;

    localparam logic [31:0] PC_INC           = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Flush counter width covers FLUSH_CYCLES up to 7.
    localparam int                CNT_W   = 3;
    localparam logic [CNT_W-1:0] CNT_ONE = 3'd1;

    function automatic logic [31:0] fall_through(input logic [31:0] pc);
        return pc + PC_INC;
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Execute/fetch facing bus of the PC sequencer; the slave modport is the
// sequencer itself, the master modport is the surrounding pipeline.
interface pc_sequencer_if;

    logic        stall_i;
    logic        fetch_ready_i;
    logic        ex_valid_i;
    logic        ex_is_ctrl_i;
    logic [31:0] ex_pc_i;
    logic [31:0] ex_pc_next_i;
    logic [31:0] pc_o;
    logic        fetch_req_o;
    logic        flush_o;
    logic        redirect_busy_o;
    logic        misalign_trap_o;
    logic [31:0] trap_epc_o;

    modport slave (
        input  stall_i, fetch_ready_i, ex_valid_i, ex_is_ctrl_i, ex_pc_i, ex_pc_next_i,
        output pc_o, fetch_req_o, flush_o, redirect_busy_o, misalign_trap_o, trap_epc_o
    );

    modport master (
        output stall_i, fetch_ready_i, ex_valid_i, ex_is_ctrl_i, ex_pc_i, ex_pc_next_i,
        input  pc_o, fetch_req_o, flush_o, redirect_busy_o, misalign_trap_o, trap_epc_o
    );

endinterface

// File: rtl/pc_sequencer_redirect_detect.sv
// Combinational redirect decision: resolved next-PC versus fall-through,
// plus target alignment. Misalignment output exists only with
// BRANCH_MISALIGN_TRAP_EN; otherwise the low target bits are cleared.
module redirect_detect
    import rv_core_pkg::*;
(
    input  logic        run,
    input  logic        ex_valid,
    input  logic        ex_is_ctrl,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_pc_next,
    output logic        redirect,
`ifdef BRANCH_MISALIGN_TRAP_EN
    output logic        misaligned,
`endif
    output logic [31:0] target
);

    assign redirect = run & ex_valid & ex_is_ctrl & (ex_pc_next != fall_through(ex_pc));

`ifdef BRANCH_MISALIGN_TRAP_EN
    assign misaligned = (ex_pc_next[1:0] != 2'b00);
    assign target     = ex_pc_next;
`else
    assign target     = {ex_pc_next[31:2], 2'b00};
`endif

endmodule

// File: rtl/pc_sequencer.sv
// Architectural fetch PC owner: sequential advance on fetch handshake and
// redirect-plus-flush on mispredicted control transfers.
// Optional feature macro: BRANCH_MISALIGN_TRAP_EN (misaligned-target trap).
module pc_sequencer
    import rv_core_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = DEFAULT_RESET_PC,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
    input  logic           clk,
    input  logic           rst_n,
    pc_sequencer_if.slave  bus
);

    seq_state_t       state_reg;
    logic [CNT_W-1:0] count_reg;
    logic [31:0]      pc_reg;
    logic             flush_reg;
    logic             busy_reg;
    logic             redirect;
    logic [31:0]      target;
    logic             advance;

`ifdef BRANCH_MISALIGN_TRAP_EN
    logic             misaligned;
    logic             trap_reg;
    logic [31:0]      epc_reg;
`endif

    redirect_detect u_detect (
        .run        (state_reg == RUN),
        .ex_valid   (bus.ex_valid_i),
        .ex_is_ctrl (bus.ex_is_ctrl_i),
        .ex_pc      (bus.ex_pc_i),
        .ex_pc_next (bus.ex_pc_next_i),
        .redirect   (redirect),
`ifdef BRANCH_MISALIGN_TRAP_EN
        .misaligned (misaligned),
`endif
        .target     (target)
    );

    // The request is unconditionally valid once reset is released.
    assign bus.fetch_req_o = rst_n;
    assign advance         = bus.fetch_req_o & bus.fetch_ready_i & ~bus.stall_i;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= RUN;
            count_reg <= '0;
            pc_reg    <= RESET_PC;
            flush_reg <= 1'b0;
            busy_reg  <= 1'b0;
`ifdef BRANCH_MISALIGN_TRAP_EN
            trap_reg  <= 1'b0;
            epc_reg   <= '0;
`endif
        end else begin
`ifdef BRANCH_MISALIGN_TRAP_EN
            trap_reg <= 1'b0;
`endif
            case (state_reg)
                RUN: begin
                    if (redirect) begin
`ifdef BRANCH_MISALIGN_TRAP_EN
                        if (misaligned) begin
                            pc_reg   <= TRAP_VECTOR;
                            trap_reg <= 1'b1;
                            epc_reg  <= bus.ex_pc_i;
                        end else begin
                            pc_reg   <= target;
                        end
`else
                        pc_reg    <= target;
`endif
                        count_reg <= CNT_W'(FLUSH_CYCLES);
                        state_reg <= FLUSH;
                        flush_reg <= 1'b1;
                        busy_reg  <= 1'b1;
                    end else if (advance) begin
                        pc_reg <= fall_through(pc_reg);
                    end
                end
                FLUSH: begin
                    // Target fetch keeps going while the wrong path drains.
                    if (advance) begin
                        pc_reg <= fall_through(pc_reg);
                    end
                    if (count_reg == CNT_ONE) begin
                        count_reg <= '0;
                        state_reg <= RUN;
                        flush_reg <= 1'b0;
                        busy_reg  <= 1'b0;
                    end else begin
                        count_reg <= count_reg - CNT_ONE;
                    end
                end
                default: begin
                    state_reg <= RUN;
                    count_reg <= '0;
                    flush_reg <= 1'b0;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pc_o            = pc_reg;
    assign bus.flush_o         = flush_reg;
    assign bus.redirect_busy_o = busy_reg;

`ifdef BRANCH_MISALIGN_TRAP_EN
    assign bus.misalign_trap_o = trap_reg;
    assign bus.trap_epc_o      = epc_reg;
`else
    assign bus.misalign_trap_o = 1'b0;
    assign bus.trap_epc_o      = '0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed vector table, hand-written
// wrap/hold/reset sequences, then random traffic against a behavioural model.
module tb_pc_sequencer;

    localparam logic [31:0] RESET_PC     = 32'h0000_0000;
    localparam int          FLUSH_CYCLES = 2;
    localparam logic [31:0] TRAP_VECTOR  = 32'h0000_0100;
`ifdef BRANCH_MISALIGN_TRAP_EN
    localparam bit TRAP_ON = 1'b1;
`else
    localparam bit TRAP_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pc_sequencer_if bus ();

    pc_sequencer #(
        .RESET_PC     (RESET_PC),
        .FLUSH_CYCLES (FLUSH_CYCLES),
        .TRAP_VECTOR  (TRAP_VECTOR)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;
    int cyc       = 0;

    // Behavioural model: flush is "cycles of flush still owed", not a state.
    logic [31:0] m_pc;
    int          m_left;
    logic        m_trap;
    logic [31:0] m_epc;
    logic        m_req;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        ready;
        logic        valid;
        logic        ctrl;
        logic [31:0] ex_pc;
        logic [31:0] ex_next;
        logic [31:0] exp_pc;
        logic        exp_flush;
        logic        exp_trap;
        logic [31:0] exp_epc;
    } vec_t;

    vec_t tbl[21];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
        else pass_cnt++;
    endtask

    task automatic model_step(input logic rst, input logic stall, input logic ready,
                              input logic valid, input logic ctrl,
                              input logic [31:0] expc, input logic [31:0] exnext);
        logic [31:0] ft;
        ft = expc + 32'd4;
        if (!rst) begin
            m_pc = RESET_PC; m_left = 0; m_trap = 1'b0; m_epc = '0; m_req = 1'b0;
        end else begin
            m_req  = 1'b1;
            m_trap = 1'b0;
            if (m_left == 0 && valid && ctrl && exnext != ft) begin
                if (TRAP_ON && (exnext % 4) != 0) begin
                    m_pc = TRAP_VECTOR; m_trap = 1'b1; m_epc = expc;
                end else begin
                    m_pc = exnext - (exnext % 4);
                end
                m_left = FLUSH_CYCLES;
            end else begin
                if (m_left > 0) m_left--;
                if (ready && !stall) m_pc = m_pc + 32'd4;
            end
        end
    endtask

    task automatic drive_cycle(input logic rst, input logic stall, input logic ready,
                               input logic valid, input logic ctrl,
                               input logic [31:0] expc, input logic [31:0] exnext);
        rst_n             = rst;
        bus.stall_i       = stall;
        bus.fetch_ready_i = ready;
        bus.ex_valid_i    = valid;
        bus.ex_is_ctrl_i  = ctrl;
        bus.ex_pc_i       = expc;
        bus.ex_pc_next_i  = exnext;
        model_step(rst, stall, ready, valid, ctrl, expc, exnext);
        @(posedge clk);
        #1;
        cyc++;
        $display("cyc %0d rst_n=%b stall=%b rdy=%b v=%b c=%b ex_pc=%h nxt=%h -> pc=%h flush=%b busy=%b trap=%b epc=%h",
                 cyc, rst, stall, ready, valid, ctrl, expc, exnext,
                 bus.pc_o, bus.flush_o, bus.redirect_busy_o, bus.misalign_trap_o, bus.trap_epc_o);
    endtask

    task automatic check_model(input string tag);
        chk($sformatf("%s pc", tag),    bus.pc_o,                   m_pc);
        chk($sformatf("%s flush", tag), 32'(bus.flush_o),           32'(m_left > 0));
        chk($sformatf("%s busy", tag),  32'(bus.redirect_busy_o),   32'(m_left > 0));
        chk($sformatf("%s trap", tag),  32'(bus.misalign_trap_o),   32'(m_trap));
        chk($sformatf("%s epc", tag),   bus.trap_epc_o,             m_epc);
        chk($sformatf("%s req", tag),   32'(bus.fetch_req_o),       32'(m_req));
    endtask

    initial begin
        logic [31:0] epc_after;
        epc_after = TRAP_ON ? 32'h40 : 32'h0;

        //             rst  stl  rdy  v    c    ex_pc       ex_next       exp_pc        fl   trap     epc
        tbl[0]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   32'h0,   32'h0000_0000, 1'b0, 1'b0,    32'h0};
        tbl[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   32'h0,   32'h0000_0004, 1'b0, 1'b0,    32'h0};
        tbl[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   32'h0,   32'h0000_0008, 1'b0, 1'b0,    32'h0};
        tbl[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   32'h0,   32'h0000_000C, 1'b0, 1'b0,    32'h0};
        tbl[4]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h20,  32'h80,  32'h0000_0080, 1'b1, 1'b0,    32'h0};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,   32'h0000_0080, 1'b1, 1'b0,    32'h0};
        tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   32'h0,   32'h0000_0084, 1'b0, 1'b0,    32'h0};
        tbl[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   32'h0,   32'h0000_0088, 1'b0, 1'b0,    32'h0};
        tbl[8]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h20,  32'h24,  32'h0000_008C, 1'b0, 1'b0,    32'h0};
        tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   32'h0,   32'h0000_0090, 1'b0, 1'b0,    32'h0};
        tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h90,  32'h200, 32'h0000_0200, 1'b1, 1'b0,    32'h0};
        tbl[11] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h200, 32'h300, 32'h0000_0200, 1'b1, 1'b0,    32'h0};
        tbl[12] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h200, 32'h300, 32'h0000_0204, 1'b0, 1'b0,    32'h0};
        tbl[13] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   32'h0,   32'h0000_0208, 1'b0, 1'b0,    32'h0};
        tbl[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,   32'h0000_0208, 1'b0, 1'b0,    32'h0};
        tbl[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,   32'h0000_0208, 1'b0, 1'b0,    32'h0};
        tbl[16] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,   32'h0000_0208, 1'b0, 1'b0,    32'h0};
        tbl[17] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   32'h0,   32'h0000_020C, 1'b0, 1'b0,    32'h0};
        tbl[18] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h40,  32'h102, 32'h0000_0100, 1'b1, TRAP_ON, epc_after};
        tbl[19] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   32'h0,   32'h0000_0104, 1'b1, 1'b0,    epc_after};
        tbl[20] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   32'h0,   32'h0000_0108, 1'b0, 1'b0,    epc_after};

        for (int i = 0; i < 21; i++) begin
            drive_cycle(tbl[i].rst, tbl[i].stall, tbl[i].ready, tbl[i].valid,
                        tbl[i].ctrl, tbl[i].ex_pc, tbl[i].ex_next);
            chk($sformatf("vec%0d pc", i),    bus.pc_o,                 tbl[i].exp_pc);
            chk($sformatf("vec%0d flush", i), 32'(bus.flush_o),         32'(tbl[i].exp_flush));
            chk($sformatf("vec%0d busy", i),  32'(bus.redirect_busy_o), 32'(tbl[i].exp_flush));
            chk($sformatf("vec%0d trap", i),  32'(bus.misalign_trap_o), 32'(tbl[i].exp_trap));
            chk($sformatf("vec%0d epc", i),   bus.trap_epc_o,           tbl[i].exp_epc);
            chk($sformatf("vec%0d req", i),   32'(bus.fetch_req_o),     32'(tbl[i].rst));
        end

        // Wrap at the top of the address space, then a 3-cycle fetch stall.
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 32'hFFFF_FFFC);
        chk("wrap target", bus.pc_o, 32'hFFFF_FFFC);
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("wrap flush done", 32'(bus.flush_o), 32'h0);
        drive_cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("wrap to zero", bus.pc_o, 32'h0);
        for (int k = 0; k < 3; k++) begin
            drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
            chk($sformatf("ready low hold %0d", k), bus.pc_o, 32'h0);
        end
        drive_cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("ready resume", bus.pc_o, 32'h4);

        // Reset asserted in the middle of a flush.
        drive_cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h10, 32'h501);
        chk("midflush flush", 32'(bus.flush_o), 32'h1);
        drive_cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("midflush rst pc",    bus.pc_o,                 RESET_PC);
        chk("midflush rst flush", 32'(bus.flush_o),         32'h0);
        chk("midflush rst busy",  32'(bus.redirect_busy_o), 32'h0);
        chk("midflush rst trap",  32'(bus.misalign_trap_o), 32'h0);
        chk("midflush rst epc",   bus.trap_epc_o,           32'h0);
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("post rst flush", 32'(bus.flush_o), 32'h0);
        chk("post rst req",   32'(bus.fetch_req_o), 32'h1);

        // Random traffic against the behavioural model.
        for (int n = 0; n < 400; n++) begin
            logic        r, s, rd, v, c;
            logic [31:0] p, q;
            r  = ($urandom_range(0, 49) != 0);
            s  = ($urandom_range(0, 3) == 0);
            rd = ($urandom_range(0, 3) != 0);
            v  = $urandom_range(0, 1);
            c  = ($urandom_range(0, 2) != 0);
            p  = $urandom & 32'hFFFF_FFFC;
            case ($urandom_range(0, 3))
                0: q = p + 32'd4;
                1: q = $urandom & 32'hFFFF_FFFC;
                2: q = $urandom | 32'h1;
                default: q = 32'hFFFF_FFFC;
            endcase
            drive_cycle(r, s, rd, v, c, p, q);
            check_model($sformatf("rand%0d", n));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
